// File: rtl/multicycle_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared definitions for the multi-cycle RV32I control unit: ALU operation
// codes, base opcodes, operand/immediate/result select encodings, the FSM
// state type and a small branch-resolution helper.
// No ports (package).
// ----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    // ALU operation codes driven on alu_control
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // RV32I base opcodes (instr[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    // ALU operand A select
    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    // Immediate format select
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // Register writeback source select (10 = live ALU result, unused here)
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;

    // Control FSM states
    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_EXEC_ADDR,
        ST_EXEC_BR,
        ST_JUMP,
        ST_EXEC_JALR,
        ST_EXEC_LUI,
        ST_EXEC_AUIPC,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_WB_ALU,
        ST_WB_MEM,
        ST_TRAP
    } state_e;

    // Branch outcome from the ALU flags. BLT/BGE run SLT, so a zero result
    // means "not less than"; BLTU/BGEU run SUB, where carry means a >= b.
    function automatic logic branchTaken(input logic [2:0] funct3,
                                         input logic       zero,
                                         input logic       carry);
        logic taken;
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = !zero;
            3'b101:  taken = zero;
            3'b110:  taken = !carry;
            3'b111:  taken = carry;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder
// Combinational decode of opcode/funct3/funct7 into the ALU operation used
// in the execute states, the comparison operation used for branches, and an
// illegal-encoding flag covering unknown opcodes and bad funct fields.
// Ports:
//   opcode_i        in  7  instr[6:0]
//   funct3_i        in  3  instr[14:12]
//   funct7_i        in  7  instr[31:25]
//   aluCtrlExec_o   out 4  ALU op for EXEC_R / EXEC_I
//   aluCtrlBranch_o out 4  ALU op for EXEC_BR
//   illegal_o       out 1  encoding is not a supported RV32I instruction
// ----------------------------------------------------------------------------
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] aluCtrlExec_o,
    output logic [3:0] aluCtrlBranch_o,
    output logic       illegal_o
);

    // The funct3 field gives the base operation for both R and I forms;
    // funct7 then refines it (SUB, SRA/SRAI) or marks the word illegal.
    // Branches pick between an equality/unsigned compare (SUB) and a signed
    // compare (SLT).
    always_comb begin
        aluCtrlExec_o   = ALU_ADD;
        aluCtrlBranch_o = ALU_SUB;
        illegal_o       = 1'b0;

        case (funct3_i)
            3'b000:  aluCtrlExec_o = ALU_ADD;
            3'b001:  aluCtrlExec_o = ALU_SLL;
            3'b010:  aluCtrlExec_o = ALU_SLT;
            3'b011:  aluCtrlExec_o = ALU_SLTU;
            3'b100:  aluCtrlExec_o = ALU_XOR;
            3'b101:  aluCtrlExec_o = ALU_SRL;
            3'b110:  aluCtrlExec_o = ALU_OR;
            default: aluCtrlExec_o = ALU_AND;
        endcase

        case (opcode_i)
            OP_R: begin
                if (funct7_i == 7'h20) begin
                    if (funct3_i == 3'b000) begin
                        aluCtrlExec_o = ALU_SUB;
                    end else if (funct3_i == 3'b101) begin
                        aluCtrlExec_o = ALU_SRA;
                    end else begin
                        illegal_o = 1'b1;
                    end
                end else if (funct7_i != 7'h00) begin
                    illegal_o = 1'b1;
                end
            end
            OP_I: begin
                // funct7 only carries meaning for the shift-immediates,
                // where it must be a clean SLLI/SRLI/SRAI pattern.
                if (funct3_i == 3'b001) begin
                    if (funct7_i != 7'h00) begin
                        illegal_o = 1'b1;
                    end
                end else if (funct3_i == 3'b101) begin
                    if (funct7_i == 7'h20) begin
                        aluCtrlExec_o = ALU_SRA;
                    end else if (funct7_i != 7'h00) begin
                        illegal_o = 1'b1;
                    end
                end
            end
            OP_BRANCH: begin
                case (funct3_i)
                    3'b000, 3'b001, 3'b110, 3'b111: aluCtrlBranch_o = ALU_SUB;
                    3'b100, 3'b101:                 aluCtrlBranch_o = ALU_SLT;
                    default:                        illegal_o = 1'b1;
                endcase
            end
            OP_LOAD, OP_STORE, OP_JAL, OP_JALR,
            OP_LUI, OP_AUIPC, OP_FENCE: begin
                illegal_o = 1'b0;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM of the multi-cycle RV32I core. Sequences fetch, decode,
// execute, memory access and writeback; drives ALU operation and operand
// selects, resolves branches from the ALU flags, and handshakes with the
// unified memory port (mem_req held until mem_ready).
// Parameters:
//   TRAP_ON_ILLEGAL  1: illegal encoding halts in TRAP; 0: treated as NOP
//   MEM_WAIT_MAX     max wait cycles per request; 0 = unlimited
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   instr[31:0]                   instruction register contents
//   mem_ready                     memory completes transfer this edge
//   alu_zero, alu_carry           ALU flags (carry: a >= b unsigned on SUB)
//   alu_control[3:0]              ALU operation
//   alu_src_a[1:0], alu_src_b[1:0], imm_sel[2:0]   datapath selects
//   mem_req, mem_we, mem_addr_src memory request, store, address source
//   ir_write, pc_write, pc_src    IR/PC update strobes and PC source
//   reg_write, result_src[1:0]    register writeback strobe and source
//   illegal_instr, bus_err        sticky trap causes
// ----------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned TRAP_ON_ILLEGAL = 1,
    parameter int unsigned MEM_WAIT_MAX    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero,
    input  logic        alu_carry,
    output logic [3:0]  alu_control,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  imm_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic        illegal_instr,
    output logic        bus_err
);

    state_e      state_q, state_d;
    logic [31:0] waitCnt_q, waitCnt_d;
    logic        illegal_q, illegal_d;
    logic        busErr_q, busErr_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [3:0]  aluCtrlExec;
    logic [3:0]  aluCtrlBranch;
    logic        decodeIllegal;
    logic        reqActive;
    logic        waitExpired;
    logic        unusedInstrBits;

    assign opcode          = instr[6:0];
    assign funct3          = instr[14:12];
    assign funct7          = instr[31:25];
    assign unusedInstrBits = ^{instr[24:15], instr[11:7]};

    assign illegal_instr = illegal_q;
    assign bus_err       = busErr_q;

    alu_decoder uAluDecoder (
        .opcode_i        (opcode),
        .funct3_i        (funct3),
        .funct7_i        (funct7),
        .aluCtrlExec_o   (aluCtrlExec),
        .aluCtrlBranch_o (aluCtrlBranch),
        .illegal_o       (decodeIllegal)
    );

    // A memory request is outstanding in exactly these three states. The
    // timeout fires on the edge where the wait count would reach the limit,
    // so with a limit of N the request stays up for N cycles before TRAP.
    assign reqActive   = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                         (state_q == ST_MEM_WR);
    assign waitExpired = (MEM_WAIT_MAX != 0) && reqActive && !mem_ready &&
                         (waitCnt_q >= (MEM_WAIT_MAX - 1));

    // State, wait counter and sticky flags. Reset abandons any pending
    // request by returning straight to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            waitCnt_q <= '0;
            illegal_q <= 1'b0;
            busErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            illegal_q <= illegal_d;
            busErr_q  <= busErr_d;
        end
    end

    // Next-state and Moore output decode. Outputs come from the current
    // state and the latched instruction; the only input-qualified strobes
    // are the fetch completion (ir_write/pc_write on mem_ready) and the
    // branch pc_write. While rst is high every output sits at its idle value
    // so nothing is written in the reset cycle even mid-transfer.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = (reqActive && !mem_ready) ? waitCnt_q + 32'd1 : 32'd0;
        illegal_d = illegal_q;
        busErr_d  = busErr_q;

        alu_control  = ALU_ADD;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_RS2;
        imm_sel      = IMM_I;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_src = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        reg_write    = 1'b0;
        result_src   = RES_ALUOUT;

        case (state_q)
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Precompute the branch/JAL target into ALUOut while the
                // opcode is being dispatched.
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                imm_sel   = (opcode == OP_JAL) ? IMM_J : IMM_B;
                if (decodeIllegal) begin
                    if (TRAP_ON_ILLEGAL != 0) begin
                        state_d   = ST_TRAP;
                        illegal_d = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    case (opcode)
                        OP_R:               state_d = ST_EXEC_R;
                        OP_I:               state_d = ST_EXEC_I;
                        OP_LOAD, OP_STORE:  state_d = ST_EXEC_ADDR;
                        OP_BRANCH:          state_d = ST_EXEC_BR;
                        OP_JAL:             state_d = ST_JUMP;
                        OP_JALR:            state_d = ST_EXEC_JALR;
                        OP_LUI:             state_d = ST_EXEC_LUI;
                        OP_AUIPC:           state_d = ST_EXEC_AUIPC;
                        default:            state_d = ST_FETCH;
                    endcase
                end
            end
            ST_EXEC_R: begin
                alu_control = aluCtrlExec;
                alu_src_a   = SRC_A_RS1;
                alu_src_b   = SRC_B_RS2;
                state_d     = ST_WB_ALU;
            end
            ST_EXEC_I: begin
                alu_control = aluCtrlExec;
                alu_src_a   = SRC_A_RS1;
                alu_src_b   = SRC_B_IMM;
                imm_sel     = IMM_I;
                state_d     = ST_WB_ALU;
            end
            ST_EXEC_LUI: begin
                alu_src_a = SRC_A_ZERO;
                alu_src_b = SRC_B_IMM;
                imm_sel   = IMM_U;
                state_d   = ST_WB_ALU;
            end
            ST_EXEC_AUIPC: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                imm_sel   = IMM_U;
                state_d   = ST_WB_ALU;
            end
            ST_EXEC_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_d   = (opcode == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                mem_req      = 1'b1;
                mem_addr_src = 1'b1;
                if (mem_ready) begin
                    state_d = ST_WB_MEM;
                end
            end
            ST_MEM_WR: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr_src = 1'b1;
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC_BR: begin
                // ALUOut still holds the target computed in DECODE.
                alu_control = aluCtrlBranch;
                alu_src_a   = SRC_A_RS1;
                alu_src_b   = SRC_B_RS2;
                imm_sel     = IMM_B;
                pc_write    = branchTaken(funct3, alu_zero, alu_carry);
                pc_src      = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_EXEC_JALR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                imm_sel   = IMM_I;
                state_d   = ST_JUMP;
            end
            ST_JUMP: begin
                // Redirect to ALUOut while computing the link value old_pc+4.
                pc_write  = 1'b1;
                pc_src    = 1'b1;
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_FOUR;
                state_d   = ST_WB_ALU;
            end
            ST_WB_ALU: begin
                reg_write  = 1'b1;
                result_src = RES_ALUOUT;
                state_d    = ST_FETCH;
            end
            ST_WB_MEM: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
                state_d    = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (waitExpired) begin
            state_d   = ST_TRAP;
            busErr_d  = 1'b1;
            waitCnt_d = 32'd0;
        end

        if (rst) begin
            alu_control  = ALU_ADD;
            alu_src_a    = SRC_A_PC;
            alu_src_b    = SRC_B_RS2;
            imm_sel      = IMM_I;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_src = 1'b0;
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            pc_src       = 1'b0;
            reg_write    = 1'b0;
            result_src   = RES_ALUOUT;
        end
    end

endmodule
